// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce/edge-detect block: FSM encoding,
// legal parameter limits and the stability-counter width helper.
package debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_PEND   = 1'b1
    } debounce_state_t;

    localparam int MIN_SYNC_STAGES     = 2;
    localparam int MIN_DEBOUNCE_CYCLES = 1;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser for a single asynchronous level, cleared to 0 by a
// synchronous active-high reset. Used for any async input entering the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw level through the flop chain; the oldest bit is the synced output.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_edge_sync.sv
// Turns a bouncing asynchronous level into a clean clk-synchronous level plus
// one-cycle rise/fall pulses. A new synced level is accepted only after it has
// been seen for DEBOUNCE_CYCLES consecutive cycles; shorter excursions are dropped.
module debounce_edge_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic data_in,
    output logic data_out,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
            $error("debounce_edge_sync: SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_debounce_cycles
            $error("debounce_edge_sync: DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    logic            synced;
    logic [CNT_W-1:0] cnt;
    debounce_state_t state;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (data_in),
        .q    (synced)
    );

    // Stability FSM: count consecutive cycles where synced differs from the
    // accepted level, accept on the last one and emit a single edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_STABLE;
            cnt      <= '0;
            data_out <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_STABLE: begin
                    cnt <= '0;
                    if (synced != data_out) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            data_out <= synced;
                            rise     <= synced;
                            fall     <= ~synced;
                        end else begin
                            state <= ST_PEND;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                ST_PEND: begin
                    if (synced == data_out) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        data_out <= synced;
                        rise     <= synced;
                        fall     <= ~synced;
                        cnt      <= '0;
                        state    <= ST_STABLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_edge_sync.sv
// Testbench for debounce_edge_sync: directed scenarios with literal latency and
// pulse-count expectations, then randomized bursts, all compared every cycle
// against a run-length model of the debouncer.
module tb_debounce_edge_sync;

    localparam int S = 2;
    localparam int D = 4;
    localparam int LAT = S + D;

    logic clk;
    logic reset;
    logic data_in;
    logic data_out;
    logic rise;
    logic fall;

    int n_checks = 0;
    int n_fail   = 0;

    debounce_edge_sync #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .data_out(data_out),
        .rise    (rise),
        .fall    (fall)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture what the DUT saw at each rising edge for the model to consume later
    logic samp_rst;
    logic samp_in;
    logic have_edge = 1'b0;
    always @(posedge clk) begin
        samp_rst  <= reset;
        samp_in   <= data_in;
        have_edge <= 1'b1;
    end

    // Model state: input samples still in flight, accepted level, run length of disagreement
    bit m_hist[$];
    bit m_out  = 1'b0;
    bit m_rise = 1'b0;
    bit m_fall = 1'b0;
    int m_run  = 0;

    initial begin
        for (int i = 0; i < S; i++) m_hist.push_back(1'b0);
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an input level reaches the decision point S edges after sampling;
    // the output flips once D consecutive decisions have disagreed with it.
    task automatic model_step(input bit rst, input bit din);
        bit seen;
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < S; i++) m_hist.push_back(1'b0);
            m_out  = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = 0;
        end else begin
            seen = m_hist.pop_front();
            m_hist.push_back(din);
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = (seen != m_out) ? m_run + 1 : 0;
            if (m_run == D) begin
                m_out  = seen;
                m_rise = seen;
                m_fall = !seen;
                m_run  = 0;
            end
        end
    endtask

    // Every falling edge: advance the model by the last rising edge and compare
    always @(negedge clk) begin
        if (have_edge) begin
            model_step(samp_rst, samp_in);
            checkOutput("data_out", data_out, m_out);
            checkOutput("rise", rise, m_rise);
            checkOutput("fall", fall, m_fall);
            checkOutput("rise_fall_exclusive", rise & fall, 1'b0);
        end
    end

    // Drive inputs away from the active edge
    task automatic applyStimulus(input logic rst, input logic din);
        @(negedge clk);
        reset   = rst;
        data_in = din;
    endtask

    // Observe a number of rising edges; edge 1 is the first after the last drive
    task automatic watch(input int cycles, output int first_rise, output int first_fall,
                         output int n_rise, output int n_fall);
        first_rise = 0;
        first_fall = 0;
        n_rise     = 0;
        n_fall     = 0;
        for (int i = 1; i <= cycles; i++) begin
            @(posedge clk);
            #1;
            if (rise === 1'b1) begin
                n_rise++;
                if (first_rise == 0) first_rise = i;
            end
            if (fall === 1'b1) begin
                n_fall++;
                if (first_fall == 0) first_fall = i;
            end
        end
    endtask

    // Time bound on the whole run
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fr, ff, nr, nf;
        int tr, tf;
        bit v;
        int len;
        bit r;

        reset   = 1'b1;
        data_in = 1'b1;

        $display("[TB] scenario 1: reset held with data_in=1");
        watch(5, fr, ff, nr, nf);
        checkInt("reset_no_rise", nr, 0);
        checkInt("reset_no_fall", nf, 0);
        checkOutput("reset_data_out", data_out, 1'b0);
        applyStimulus(1'b0, 1'b1);
        watch(10, fr, ff, nr, nf);
        checkInt("release_rise_edge", fr, LAT);
        checkInt("release_rise_count", nr, 1);
        checkInt("release_fall_count", nf, 0);
        checkOutput("release_data_out", data_out, 1'b1);

        $display("[TB] scenario 4: step down");
        applyStimulus(1'b0, 1'b0);
        watch(10, fr, ff, nr, nf);
        checkInt("stepdown_fall_edge", ff, LAT);
        checkInt("stepdown_fall_count", nf, 1);
        checkInt("stepdown_rise_count", nr, 0);
        checkOutput("stepdown_data_out", data_out, 1'b0);

        $display("[TB] scenario 3: short glitch");
        applyStimulus(1'b0, 1'b1);
        watch(3, fr, ff, tr, tf);
        applyStimulus(1'b0, 1'b0);
        watch(10, fr, ff, nr, nf);
        checkInt("glitch_rise_count", nr + tr, 0);
        checkInt("glitch_fall_count", nf + tf, 0);
        checkOutput("glitch_data_out", data_out, 1'b0);

        $display("[TB] scenario 2: clean step up");
        applyStimulus(1'b0, 1'b1);
        watch(10, fr, ff, nr, nf);
        checkInt("step_rise_edge", fr, LAT);
        checkInt("step_rise_count", nr, 1);
        checkInt("step_fall_count", nf, 0);

        applyStimulus(1'b0, 1'b0);
        watch(10, fr, ff, nr, nf);

        $display("[TB] scenario 5: reset while pending");
        applyStimulus(1'b0, 1'b1);
        watch(4, fr, ff, tr, tf);
        applyStimulus(1'b1, 1'b1);
        watch(1, fr, ff, nr, nf);
        tr += nr;
        tf += nf;
        checkInt("midpend_no_pulse", tr + tf, 0);
        checkOutput("midpend_data_out", data_out, 1'b0);
        applyStimulus(1'b0, 1'b1);
        watch(10, fr, ff, nr, nf);
        checkInt("midpend_rise_edge", fr, LAT);
        checkInt("midpend_rise_count", nr, 1);

        applyStimulus(1'b0, 1'b0);
        watch(10, fr, ff, nr, nf);

        $display("[TB] scenario 6: bounce then hold");
        tr = 0;
        tf = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, (k % 2 == 0) ? 1'b1 : 1'b0);
            watch(1, fr, ff, nr, nf);
            tr += nr;
            tf += nf;
        end
        applyStimulus(1'b0, 1'b1);
        watch(10, fr, ff, nr, nf);
        checkInt("bounce_rise_edge", fr, LAT);
        checkInt("bounce_rise_count", nr + tr, 1);
        checkInt("bounce_fall_count", nf + tf, 0);

        $display("[TB] random bursts");
        for (int k = 0; k < 400; k++) begin
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            r   = ($urandom_range(0, 40) == 0);
            for (int j = 0; j < len; j++) applyStimulus(r, v);
        end
        applyStimulus(1'b0, 1'b0);
        watch(12, fr, ff, nr, nf);
        checkOutput("final_data_out", data_out, 1'b0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
